// File: rtl/nn_batch_runner_if.sv
// Control, label-memory, network and result signals of nn_batch_runner.
// classCorrect is present only when NN_RUNNER_PERCLASS_EN is defined.
interface nn_batch_runner_if #(
    parameter int NUM_IMAGES  = 8,
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 16
);
    localparam int IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
    localparam int CW = $clog2(NUM_CLASSES);
    localparam int NW = $clog2(NUM_IMAGES + 1);

    logic                  start;
    logic [IW-1:0]         imgAddr;
    logic [CW-1:0]         label;
    logic                  NNvalid;
    logic                  NNoutValid;
    logic [CW-1:0]         maxIndex;
    logic [DATA_WIDTH-1:0] maxValue;
    logic                  resultValid;
    logic [IW-1:0]         resultIndex;
    logic                  resultCorrect;
    logic [DATA_WIDTH-1:0] resultValue;
    logic [NW-1:0]         correctCount;
    logic [NW-1:0]         timeoutCount;
    logic                  busy;
    logic                  done;
`ifdef NN_RUNNER_PERCLASS_EN
    logic [NUM_CLASSES*NW-1:0] classCorrect;
`endif

    modport master (
`ifdef NN_RUNNER_PERCLASS_EN
        output classCorrect,
`endif
        input  start, label, NNoutValid, maxIndex, maxValue,
        output imgAddr, NNvalid, resultValid, resultIndex, resultCorrect,
               resultValue, correctCount, timeoutCount, busy, done
    );

    modport slave (
`ifdef NN_RUNNER_PERCLASS_EN
        input  classCorrect,
`endif
        output start, label, NNoutValid, maxIndex, maxValue,
        input  imgAddr, NNvalid, resultValid, resultIndex, resultCorrect,
               resultValue, correctCount, timeoutCount, busy, done
    );
endinterface

// File: rtl/nn_batch_runner.sv
// Steps a batch of images through an external classifier and scores each result.
// Optional per-class correct counters: define NN_RUNNER_PERCLASS_EN.
module nn_batch_runner #(
    parameter int NUM_IMAGES     = 8,
    parameter int NUM_CLASSES    = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    nn_batch_runner_if.master nn
);
    localparam int IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
    localparam int CW = $clog2(NUM_CLASSES);
    localparam int NW = $clog2(NUM_IMAGES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT, S_SCORE, S_DONE
    } state_t;

    state_t                state, state_nx;
    logic [IW-1:0]         addr_q;
    logic [CW-1:0]         label_q;
    logic [CW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] val_q;
    logic                  timeout_q;
    logic [TW-1:0]         timer_q;
    logic [NW-1:0]         correct_q;
    logic [NW-1:0]         tmo_q;
    logic                  last_img;
    logic                  hit_timeout;
    logic                  is_correct;

    assign last_img    = (addr_q == IW'(NUM_IMAGES - 1));
    assign hit_timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign is_correct  = (idx_q == label_q) && !timeout_q;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // A result arriving on the timeout cycle wins over the timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE,
            S_DONE:  if (nn.start) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   state_nx = S_WAIT;
            S_WAIT:  if (nn.NNoutValid || hit_timeout) state_nx = S_SCORE;
            S_SCORE: state_nx = last_img ? S_DONE : S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        nn.NNvalid       = (state == S_RUN);
        nn.busy          = (state != S_IDLE) && (state != S_DONE);
        nn.done          = (state == S_DONE);
        nn.resultValid   = 1'b0;
        nn.resultIndex   = '0;
        nn.resultCorrect = 1'b0;
        nn.resultValue   = '0;
        if (state == S_SCORE) begin
            nn.resultValid   = 1'b1;
            nn.resultIndex   = addr_q;
            nn.resultCorrect = is_correct;
            nn.resultValue   = val_q;
        end
    end

    assign nn.imgAddr      = addr_q;
    assign nn.correctCount = correct_q;
    assign nn.timeoutCount = tmo_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q    <= '0;
            label_q   <= '0;
            idx_q     <= '0;
            val_q     <= '0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
            correct_q <= '0;
            tmo_q     <= '0;
        end else begin
            case (state)
                S_IDLE,
                S_DONE: if (nn.start) begin
                    addr_q    <= '0;
                    correct_q <= '0;
                    tmo_q     <= '0;
                end
                S_LOAD: label_q <= nn.label;
                S_RUN: begin
                    timer_q   <= '0;
                    timeout_q <= 1'b0;
                end
                S_WAIT: begin
                    if (nn.NNoutValid) begin
                        idx_q <= nn.maxIndex;
                        val_q <= nn.maxValue;
                    end else if (hit_timeout) begin
                        timeout_q <= 1'b1;
                        val_q     <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_SCORE: begin
                    if (is_correct && correct_q != NW'(NUM_IMAGES))
                        correct_q <= correct_q + 1'b1;
                    if (timeout_q && tmo_q != NW'(NUM_IMAGES))
                        tmo_q <= tmo_q + 1'b1;
                    if (!last_img)
                        addr_q <= addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef NN_RUNNER_PERCLASS_EN
    logic [NW-1:0] class_q [NUM_CLASSES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) class_q[k] <= '0;
        end else if ((state == S_IDLE || state == S_DONE) && nn.start) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) class_q[k] <= '0;
        end else if (state == S_SCORE && is_correct) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++)
                if (label_q == CW'(k) && class_q[k] != NW'(NUM_IMAGES))
                    class_q[k] <= class_q[k] + 1'b1;
        end
    end

    always_comb begin
        nn.classCorrect = '0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++)
            nn.classCorrect[k*NW +: NW] = class_q[k];
    end
`endif

endmodule

// File: tb/tb_nn_batch_runner.sv
// Self-checking bench for nn_batch_runner: scenario table, random batches, reset abort.
// Define NN_RUNNER_PERCLASS_EN to also check classCorrect.
`timescale 1ns/1ps
module tb_nn_batch_runner;
    localparam int NI = 8;
    localparam int NC = 10;
    localparam int DW = 16;
    localparam int TO = 24;
    localparam int CW = $clog2(NC);
    localparam int NW = $clog2(NI + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    nn_batch_runner_if #(.NUM_IMAGES(NI), .NUM_CLASSES(NC), .DATA_WIDTH(DW)) bus ();

    nn_batch_runner #(
        .NUM_IMAGES(NI), .NUM_CLASSES(NC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .nn(bus)
    );

    typedef struct {
        string name;
        int    mode;
        int    exp_cc;
        int    exp_tc;
    } vec_t;

    int compared = 0;
    int mismatched = 0;

    // Per-image plan for the network model; p_delay counts WAIT cycles before the result.
    int p_label[NI], p_pred[NI], p_val[NI], p_delay[NI];
    bit p_resp[NI];
    bit spur;

    // Reference expectations, computed from the plan.
    bit m_correct[NI];
    int m_value[NI], m_lat[NI];
    int m_cc, m_tc;
    int m_class[NC];

    bit armed, prev_rv, mon;
    int cnt, arm_img, cyc, run_cyc, exp_run, exp_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build_model();
        bit got;
        m_cc = 0;
        m_tc = 0;
        for (int k = 0; k < NC; k++) m_class[k] = 0;
        for (int i = 0; i < NI; i++) begin
            got = p_resp[i] && (p_delay[i] < TO);
            m_correct[i] = got && (p_pred[i] == p_label[i]);
            m_value[i]   = got ? p_val[i] : 0;
            m_lat[i]     = got ? p_delay[i] + 2 : TO + 1;
            if (m_correct[i]) begin
                m_cc++;
                m_class[p_label[i]]++;
            end
            if (!got) m_tc++;
        end
    endtask

    task automatic plan(input int mode);
        spur = 1'b0;
        for (int i = 0; i < NI; i++) begin
            p_label[i] = i;
            p_pred[i]  = i;
            p_val[i]   = $urandom_range(1, 65535);
            p_delay[i] = 20;
            p_resp[i]  = 1'b1;
            case (mode)
                1: begin p_delay[i] = 5; if (i % 2 == 1) p_pred[i] = (i + 1) % NC; end
                2: begin p_delay[i] = 3; if (i == 3) p_resp[i] = 1'b0; end
                3: begin p_label[i] = 9 - i; p_pred[i] = 9 - i; p_delay[i] = TO - 1; end
                4: begin p_label[i] = i % 3; p_pred[i] = i % 3; p_delay[i] = 0; spur = 1'b1; end
                5: p_delay[i] = TO;
                6: begin p_label[i] = 2; p_pred[i] = 2; p_delay[i] = 1; end
                99: begin
                    p_label[i] = $urandom_range(0, NC - 1);
                    p_pred[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NC - 1) : p_label[i];
                    p_delay[i] = $urandom_range(0, TO);
                    p_resp[i]  = ($urandom_range(0, 7) != 0);
                    spur       = ($urandom_range(0, 1) == 1);
                end
                default: ;
            endcase
        end
        build_model();
    endtask

    // One clock: sample at the falling edge, then drive the network and label memory.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (mon && bus.NNvalid) begin
            chk("run_img_addr", bus.imgAddr, exp_run);
            exp_run++;
            run_cyc = cyc;
        end
        if (mon && bus.resultValid) begin
            chk("result_index", bus.resultIndex, exp_res);
            if (exp_res < NI) begin
                chk("result_correct", bus.resultCorrect, m_correct[exp_res]);
                chk("result_value", bus.resultValue, m_value[exp_res]);
                chk("result_latency", cyc - run_cyc, m_lat[exp_res]);
            end
            exp_res++;
        end
        bus.NNoutValid = 1'b0;
        if (armed) begin
            if (cnt == 0) begin
                bus.NNoutValid = 1'b1;
                bus.maxIndex   = CW'(p_pred[arm_img]);
                bus.maxValue   = DW'(p_val[arm_img]);
                armed = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (bus.NNvalid && p_resp[bus.imgAddr]) begin
            armed   = 1'b1;
            cnt     = p_delay[bus.imgAddr];
            arm_img = int'(bus.imgAddr);
        end
        if (spur && !bus.NNoutValid && (bus.resultValid || (bus.busy && prev_rv))) begin
            bus.NNoutValid = 1'b1;
            bus.maxIndex   = CW'(p_label[bus.imgAddr]);
            bus.maxValue   = '1;
        end
        prev_rv   = bus.resultValid;
        bus.label = CW'(p_label[bus.imgAddr]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_imgAddr"}, bus.imgAddr, 0);
        chk({tag, "_NNvalid"}, bus.NNvalid, 0);
        chk({tag, "_resultValid"}, bus.resultValid, 0);
        chk({tag, "_resultIndex"}, bus.resultIndex, 0);
        chk({tag, "_resultCorrect"}, bus.resultCorrect, 0);
        chk({tag, "_resultValue"}, bus.resultValue, 0);
        chk({tag, "_correctCount"}, bus.correctCount, 0);
        chk({tag, "_timeoutCount"}, bus.timeoutCount, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
`ifdef NN_RUNNER_PERCLASS_EN
        chk({tag, "_classCorrect"}, bus.classCorrect, 0);
`endif
    endtask

    task automatic run_batch(input string name, input int exp_cc, input int exp_tc);
        exp_run = 0;
        exp_res = 0;
        armed   = 1'b0;
        mon     = 1'b1;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk({name, "_busy_after_start"}, bus.busy, 1);
        chk({name, "_cleared_on_start"}, bus.correctCount, 0);
        for (int n = 0; n < NI * (TO + 6); n++) begin
            cycle();
            if (bus.done) break;
        end
        chk({name, "_done"}, bus.done, 1);
        chk({name, "_result_pulses"}, exp_res, NI);
        chk({name, "_correctCount"}, bus.correctCount, exp_cc);
        chk({name, "_timeoutCount"}, bus.timeoutCount, exp_tc);
`ifdef NN_RUNNER_PERCLASS_EN
        for (int k = 0; k < NC; k++)
            chk({name, "_classCorrect"}, bus.classCorrect[k*NW +: NW], m_class[k]);
`endif
        cycle();
        cycle();
        chk({name, "_hold_correct"}, bus.correctCount, exp_cc);
        chk({name, "_hold_busy"}, bus.busy, 0);
        chk({name, "_hold_done"}, bus.done, 1);
        mon = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"all_correct_d20",   0, 8, 0};
        vecs[1] = '{"alternating",       1, 4, 0};
        vecs[2] = '{"img3_timeout",      2, 7, 1};
        vecs[3] = '{"result_on_timeout", 3, 8, 0};
        vecs[4] = '{"spurious_strobes",  4, 8, 0};
        vecs[5] = '{"result_too_late",   5, 0, 8};
        vecs[6] = '{"all_label2",        6, 8, 0};

        bus.start = 1'b0;
        bus.NNoutValid = 1'b0;
        bus.maxIndex = '0;
        bus.maxValue = '0;
        bus.label = '0;
        mon = 1'b0;
        cyc = 0;
        plan(0);

        repeat (3) cycle();
        check_all_zero("reset");
        reset = 1'b1;
        cycle();
        chk("idle_no_start_busy", bus.busy, 0);
        chk("idle_no_start_done", bus.done, 0);

        foreach (vecs[v]) begin
            plan(vecs[v].mode);
            run_batch(vecs[v].name, vecs[v].exp_cc, vecs[v].exp_tc);
        end

        for (int r = 0; r < 12; r++) begin
            plan(99);
            run_batch("random", m_cc, m_tc);
        end

        // Abort a batch while image 5 waits for the network.
        plan(0);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int n = 0; n < NI * (TO + 6); n++) begin
            cycle();
            if (bus.NNvalid && bus.imgAddr == 5) break;
        end
        chk("abort_reached_img5", bus.imgAddr, 5);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        armed = 1'b0;
        check_all_zero("abort");
        run_batch("after_abort", 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
